// File: rtl/doa_arctan_pkg.sv
// Shared constants and elaboration-time helpers for the DOA arctan CORDIC.
// The ATAN table is derived here so that it follows ANGLE_WIDTH automatically.
package doa_arctan_pkg;

  localparam int HEADROOM_BITS = 2;
  // Fraction bits below the input LSB so shift truncation does not bias small vectors.
  localparam int GUARD_BITS    = 6;
  localparam int ATAN_ENTRIES  = 16;
  localparam longint PI_Q40    = 64'sd3454217652358;

  function automatic int cordic_width(input int din_w);
    return din_w + HEADROOM_BITS + GUARD_BITS;
  endfunction

  function automatic int index_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // round(atan(2^-i)/pi * 2^(aw-1)); Taylor series evaluated in Q40 integer arithmetic.
  function automatic int atan_lsb(input int i, input int aw);
    longint term;
    longint sum;
    if (i == 0) return 1 << (aw - 3);
    sum  = 0;
    term = longint'(1) << (40 - i);
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) sum = sum + term / longint'(2 * k + 1);
      else            sum = sum - term / longint'(2 * k + 1);
      term = term >>> (2 * i);
    end
    return int'((sum * (longint'(1) << (aw - 1)) + PI_Q40 / 2) / PI_Q40);
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring-mode CORDIC micro-rotation (drives y toward zero).
module cordic_vec_stage #(
  parameter int W     = 26,
  parameter int AW    = 16,
  parameter int SHIFT = 0,
  parameter int ATAN  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic signed [W-1:0]  x_i,
  input  logic signed [W-1:0]  y_i,
  input  logic signed [AW-1:0] z_i,
  output logic                 valid_o,
  output logic signed [W-1:0]  x_o,
  output logic signed [W-1:0]  y_o,
  output logic signed [AW-1:0] z_o
);

  localparam logic signed [AW-1:0] ATAN_C = AW'(ATAN);

  logic                 valid_q;
  logic signed [W-1:0]  x_q, x_d, y_q, y_d, xs, ys;
  logic signed [AW-1:0] z_q, z_d;

  always_comb begin
    xs = x_i >>> SHIFT;
    ys = y_i >>> SHIFT;
    if (!y_i[W-1]) begin
      x_d = x_i + ys;
      y_d = y_i - xs;
      z_d = z_i + ATAN_C;
    end else begin
      x_d = x_i - ys;
      y_d = y_i + xs;
      z_d = z_i - ATAN_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_i;
  end

  always_ff @(posedge clk) begin
    if (valid_i) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;

endmodule

// File: rtl/doa_arctan_cordic.sv
// Dominant-eigenvector selection and pipelined atan2 (units of pi) per DOA channel.
// Latency ITERS+2, one sample per clock, each output tagged with its channel index.
module doa_arctan_cordic import doa_arctan_pkg::*; #(
  parameter int DIN_WIDTH   = 16,
  parameter int DIN_POINT   = 10,
  parameter int VECTOR_LEN  = 64,
  parameter int ITERS       = 14,
  parameter int ANGLE_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic signed [DIN_WIDTH-1:0]            lamb1,
  input  logic signed [DIN_WIDTH-1:0]            lamb2,
  input  logic signed [DIN_WIDTH-1:0]            eigen1_y,
  input  logic signed [DIN_WIDTH-1:0]            eigen2_y,
  input  logic signed [DIN_WIDTH-1:0]            eigen_x,
  input  logic                                   din_valid,
  input  logic                                   din_error,
  output logic signed [ANGLE_WIDTH-1:0]          angle,
  output logic                                   dom_sel,
  output logic [index_width(VECTOR_LEN)-1:0]     ch_index,
  output logic                                   dout_valid,
  output logic                                   dout_error
);

  localparam int W   = cordic_width(DIN_WIDTH);
  localparam int IW  = index_width(VECTOR_LEN);
  localparam int SBW = IW + 3;

  if ((VECTOR_LEN < 2) || ((VECTOR_LEN & (VECTOR_LEN - 1)) != 0)) begin : g_bad_len
    $error("VECTOR_LEN must be a power of two");
  end
  if ((ITERS < 8) || (ITERS > ATAN_ENTRIES)) begin : g_bad_iters
    $error("ITERS must be within 8..16");
  end
  if ((DIN_POINT < 0) || (DIN_POINT > DIN_WIDTH)) begin : g_bad_point
    $error("DIN_POINT must lie within the input word");
  end

  logic                          sel_c, zero_c;
  logic signed [DIN_WIDTH-1:0]   ysel_c;
  logic signed [W-1:0]           x_ext, y_ext, x0_d, y0_d, x0_q, y0_q;
  logic signed [ANGLE_WIDTH-1:0] z0_d, z0_q;
  logic                          vld0_q;
  logic [IW-1:0]                 ch_q, ch_d;

  logic                          vld_s [ITERS+1];
  logic signed [W-1:0]           x_s   [ITERS+1];
  logic signed [W-1:0]           y_s   [ITERS+1];
  logic signed [ANGLE_WIDTH-1:0] z_s   [ITERS+1];
  logic [SBW-1:0]                sb_q  [ITERS+1];
  logic [SBW-1:0]                sb_last;

  logic                          dout_valid_q, dout_error_q, dom_sel_q;
  logic signed [ANGLE_WIDTH-1:0] angle_q;
  logic [IW-1:0]                 ch_index_q;

  // Stage 0: eigenvector selection, width extension, pre-rotation into the right half-plane
  always_comb begin
    sel_c  = lamb2 > lamb1;
    ysel_c = sel_c ? eigen2_y : eigen1_y;
    x_ext  = {{HEADROOM_BITS{eigen_x[DIN_WIDTH-1]}}, eigen_x, {GUARD_BITS{1'b0}}};
    y_ext  = {{HEADROOM_BITS{ysel_c[DIN_WIDTH-1]}}, ysel_c, {GUARD_BITS{1'b0}}};
    zero_c = (eigen_x == '0) && (ysel_c == '0);
    if (eigen_x[DIN_WIDTH-1]) begin
      x0_d = -x_ext;
      y0_d = -y_ext;
      z0_d = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
    end else begin
      x0_d = x_ext;
      y0_d = y_ext;
      z0_d = '0;
    end
    ch_d = ch_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_q <= 1'b0;
      ch_q   <= '0;
    end else begin
      vld0_q <= din_valid;
      if (din_valid) ch_q <= ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (din_valid) begin
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      z0_q     <= z0_d;
      sb_q[0]  <= {sel_c, zero_c, din_error, ch_q};
    end
    for (int k = 1; k <= ITERS; k++) begin
      if (vld_s[k-1]) sb_q[k] <= sb_q[k-1];
    end
  end

  assign vld_s[0] = vld0_q;
  assign x_s[0]   = x0_q;
  assign y_s[0]   = y0_q;
  assign z_s[0]   = z0_q;

  // Stages 1..ITERS: micro-rotations
  for (genvar g = 0; g < ITERS; g++) begin : g_stage
    cordic_vec_stage #(
      .W     (W),
      .AW    (ANGLE_WIDTH),
      .SHIFT (g),
      .ATAN  (atan_lsb(g, ANGLE_WIDTH))
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (vld_s[g]),
      .x_i     (x_s[g]),
      .y_i     (y_s[g]),
      .z_i     (z_s[g]),
      .valid_o (vld_s[g+1]),
      .x_o     (x_s[g+1]),
      .y_o     (y_s[g+1]),
      .z_o     (z_s[g+1])
    );
  end

  assign sb_last = sb_q[ITERS];

  // Output stage: undefined angle forced to 0 and flagged as an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      dout_error_q <= 1'b0;
      dom_sel_q    <= 1'b0;
      angle_q      <= '0;
      ch_index_q   <= '0;
    end else begin
      dout_valid_q <= vld_s[ITERS];
      dout_error_q <= vld_s[ITERS] & (sb_last[IW] | sb_last[IW+1]);
      if (vld_s[ITERS]) begin
        angle_q    <= sb_last[IW+1] ? '0 : z_s[ITERS];
        dom_sel_q  <= sb_last[IW+2];
        ch_index_q <= sb_last[IW-1:0];
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_error = dout_error_q;
  assign dom_sel    = dom_sel_q;
  assign angle      = angle_q;
  assign ch_index   = ch_index_q;

endmodule

// File: tb/tb_doa_arctan_cordic.sv
// Directed bench for doa_arctan_cordic: latency, quadrant angles, selection, flags,
// channel indexing over a gapped stream, and asynchronous reset mid-flight.
module tb_doa_arctan_cordic;

  typedef struct packed {
    logic [15:0] ang;
    logic        sel;
    logic [5:0]  ch;
    logic        err;
  } obs_t;

  typedef struct packed {
    logic [15:0] ang;
    logic        sel;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [15:0] lamb1 = '0, lamb2 = '0, eigen1_y = '0, eigen2_y = '0, eigen_x = '0;
  logic               din_valid = 1'b0, din_error = 1'b0;
  logic [15:0]        angle;
  logic               dom_sel;
  logic [5:0]         ch_index;
  logic               dout_valid, dout_error;

  int   n_err = 0;
  int   n_checks = 0;
  obs_t outq[$];
  exp_t expq[$];

  int tx[4] = '{0, 1024, -1024, 0};
  int ty[4] = '{1024, 1024, 0, -1024};
  int te[4] = '{16384, 8192, -32768, -16384};

  always #5 clk = ~clk;

  doa_arctan_cordic #(
    .DIN_WIDTH(16), .DIN_POINT(10), .VECTOR_LEN(64), .ITERS(14), .ANGLE_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lamb1(lamb1), .lamb2(lamb2),
    .eigen1_y(eigen1_y), .eigen2_y(eigen2_y), .eigen_x(eigen_x),
    .din_valid(din_valid), .din_error(din_error),
    .angle(angle), .dom_sel(dom_sel), .ch_index(ch_index),
    .dout_valid(dout_valid), .dout_error(dout_error)
  );

  always @(negedge clk) begin
    if (dout_valid === 1'b1) outq.push_back({angle, dom_sel, ch_index, dout_error});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ang(input string tag, input logic [15:0] obs, input int exp);
    logic [15:0]        e16;
    logic signed [15:0] d;
    logic               ok;
    e16 = 16'(exp);
    d   = signed'(obs - e16);
    ok  = (d >= -16'sd4) && (d <= 16'sd4);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: got angle %0d expected %0d +-4", tag, $signed(obs), $signed(e16));
    end
  endtask

  task automatic put(input int l1, input int l2, input int e1, input int e2, input int x,
                     input logic er);
    @(negedge clk);
    lamb1 = 16'(l1); lamb2 = 16'(l2);
    eigen1_y = 16'(e1); eigen2_y = 16'(e2); eigen_x = 16'(x);
    din_valid = 1'b1; din_error = er;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0; din_error = 1'b0;
  endtask

  task automatic get(output obs_t o, output logic got);
    int n;
    n = 0; got = 1'b0; o = '0;
    while (outq.size() == 0 && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (outq.size() != 0) begin
      o = outq.pop_front();
      got = 1'b1;
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  initial begin
    obs_t o, o2;
    exp_t e;
    logic got;
    int   lat, nv, exp_ch;
    int   x, y1, y2, l1, l2, yy, ei;
    real  r;

    #3 rst_n = 1'b0;
    #2 chk("reset_state", 32'({dout_valid, dout_error, dom_sel, ch_index, angle}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    put(2048, 0, 0, 0, 1024, 1'b0);
    lat = 0; nv = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (n == 1) din_valid = 1'b0;
      if (dout_valid) begin
        nv++;
        if (lat == 0) lat = n;
      end
    end
    chk("latency", 32'(lat), 32'd16);
    chk("valid_pulses", 32'(nv), 32'd1);
    get(o, got);
    chk("lat_out", 32'(got), 32'd1);
    chk_ang("lat_angle", o.ang, 0);
    chk("lat_sel", 32'(o.sel), 32'd0);
    chk("lat_ch", 32'(o.ch), 32'd0);
    chk("lat_err", 32'(o.err), 32'd0);
    exp_ch = 1;

    for (int i = 0; i < 4; i++) begin
      put(100, 0, ty[i], 0, tx[i], 1'b0);
      idle();
      get(o, got);
      chk("quad_out", 32'(got), 32'd1);
      chk_ang("quad_angle", o.ang, te[i]);
      chk("quad_sel", 32'(o.sel), 32'd0);
      chk("quad_ch", 32'(o.ch), 32'(exp_ch));
      exp_ch++;
    end

    put(1000, 3000, -1024, 1024, 1024, 1'b0);
    idle();
    get(o, got);
    chk("sel2_sel", 32'(o.sel), 32'd1);
    chk_ang("sel2_angle", o.ang, 8192);
    chk("sel2_ch", 32'(o.ch), 32'd5);

    put(1000, 1000, -1024, 1024, 1024, 1'b0);
    idle();
    get(o, got);
    chk("tie_sel", 32'(o.sel), 32'd0);
    chk_ang("tie_angle", o.ang, -8192);

    put(100, 0, 0, 0, 0, 1'b0);
    idle();
    get(o, got);
    chk("zero_angle", 32'(o.ang), 32'd0);
    chk("zero_err", 32'(o.err), 32'd1);

    put(100, 0, 1024, 0, 1024, 1'b1);
    put(100, 0, 1024, 0, 1024, 1'b0);
    idle();
    get(o, got);
    get(o2, got);
    chk("din_err_flag", 32'(o.err), 32'd1);
    chk("din_err_next", 32'(o2.err), 32'd0);
    chk_ang("din_err_angle", o2.ang, 8192);

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    outq.delete();
    for (int i = 0; i < 130; i++) begin
      do begin
        x  = int'($urandom_range(0, 32000)) - 16000;
        y1 = int'($urandom_range(0, 32000)) - 16000;
        y2 = int'($urandom_range(0, 32000)) - 16000;
        l1 = int'($urandom_range(0, 40000)) - 20000;
        l2 = int'($urandom_range(0, 40000)) - 20000;
        yy = (l2 > l1) ? y2 : y1;
      end while (iabs(x) < 1000 && iabs(yy) < 1000);
      r  = $atan2(real'(yy), real'(x)) * 32768.0 / 3.141592653589793;
      ei = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      e.ang = 16'(ei);
      e.sel = (l2 > l1);
      expq.push_back(e);
      put(l1, l2, y1, y2, x, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat (int'($urandom_range(0, 2))) @(negedge clk);
      end
    end
    idle();
    repeat (30) @(negedge clk);
    #1;
    chk("stream_count", 32'(outq.size()), 32'd130);
    for (int i = 0; i < 130; i++) begin
      if (outq.size() == 0) break;
      o = outq.pop_front();
      e = expq[i];
      chk_ang("stream_angle", o.ang, int'($signed(e.ang)));
      chk("stream_ch", 32'(o.ch), 32'(i % 64));
      chk("stream_sel", 32'(o.sel), 32'(e.sel));
    end

    for (int i = 0; i < 20; i++) put(100, 0, 1024, 0, 1024, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    #2;
    chk("pre_reset_valid", 32'(dout_valid), 32'd1);
    chk_ang("pre_reset_angle", angle, 8192);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({dout_valid, dout_error, dom_sel, ch_index, angle}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    outq.delete();
    repeat (30) @(negedge clk);
    #1;
    chk("no_stale_valid", 32'(outq.size()), 32'd0);
    put(100, 0, 1024, 0, 1024, 1'b0);
    idle();
    get(o, got);
    chk("post_reset_out", 32'(got), 32'd1);
    chk("post_reset_ch", 32'(o.ch), 32'd0);
    chk_ang("post_reset_angle", o.ang, 8192);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
